// File: rtl/mmr_initiator.sv
// mmr_initiator: bus initiator for the strobe/rw/addr/data register bus.
// Takes one command (single access or incrementing burst) over req_valid/
// req_ready, drives strobe cycles on the bus and returns one response per
// read word, or a single ack per write command, over rsp_valid/rsp_ready.
// Ports:
//   clk, reset_n             clock, synchronous active-low reset
//   req_valid/req_ready      command handshake
//   req_rw/addr/data/len     command fields (burst = req_len+1 words)
//   strobe, rw, addr, d_out  register bus outputs (all registered)
//   d_in                     registered read data from the responders
//   rsp_valid/rsp_ready      response handshake
//   rsp_data, rsp_last       read word (0 for write ack), final-response flag
//   busy                     high whenever the FSM is not idle
module mmr_initiator #(
  parameter int ABITS = 32,
  parameter int PBITS = 32,
  parameter int LBITS = 4,
  parameter int ASTEP = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_rw,
  input  logic [ABITS-1:0] req_addr,
  input  logic [PBITS-1:0] req_data,
  input  logic [LBITS-1:0] req_len,
  output logic             strobe,
  output logic             rw,
  output logic [ABITS-1:0] addr,
  output logic [PBITS-1:0] d_out,
  input  logic [PBITS-1:0] d_in,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [PBITS-1:0] rsp_data,
  output logic             rsp_last,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  localparam logic [ABITS-1:0] STEP = ABITS'(ASTEP);

  state_t             state_q, state_d;
  logic               strobe_q, strobe_d;
  logic               rw_q, rw_d;
  logic [ABITS-1:0]   addr_q, addr_d;
  logic [PBITS-1:0]   dout_q, dout_d;
  logic [LBITS-1:0]   rem_q, rem_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [PBITS-1:0]   rsp_data_q, rsp_data_d;
  logic               rsp_last_q, rsp_last_d;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid) state_d = ISSUE;
      ISSUE:   if (!rw_q) state_d = CAPTURE;
               else if (rem_q == '0) state_d = RESP;
      CAPTURE: state_d = RESP;
      RESP:    if (rsp_ready) state_d = rsp_last_q ? IDLE : ISSUE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values. strobe and rsp_valid are registered
  // decodes of the next state so they line up exactly with ISSUE and RESP.
  always_comb begin
    rw_d       = rw_q;
    addr_d     = addr_q;
    dout_d     = dout_q;
    rem_d      = rem_q;
    rsp_data_d = rsp_data_q;
    rsp_last_d = rsp_last_q;
    unique case (state_q)
      IDLE: if (req_valid) begin
        rw_d   = req_rw;
        addr_d = req_addr;
        dout_d = req_data;
        rem_d  = req_len;
      end
      ISSUE: if (rw_q) begin
        if (rem_q != '0) begin
          // write bursts strobe back-to-back; advance in place
          addr_d = addr_q + STEP;
          rem_d  = rem_q - LBITS'(1);
        end else begin
          rsp_data_d = '0;
          rsp_last_d = 1'b1;
        end
      end
      CAPTURE: begin
        // d_in is the responders' registered answer to last cycle's strobe
        rsp_data_d = d_in;
        rsp_last_d = (rem_q == '0);
      end
      RESP: if (rsp_ready && !rsp_last_q) begin
        addr_d = addr_q + STEP;
        rem_d  = rem_q - LBITS'(1);
      end
      default: ;
    endcase
    strobe_d    = (state_d == ISSUE);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      strobe_q    <= 1'b0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      dout_q      <= '0;
      rem_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
    end else begin
      strobe_q    <= strobe_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
      rem_q       <= rem_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
    end
  end

  assign req_ready = (state_q == IDLE) && reset_n;
  assign busy      = (state_q != IDLE);
  assign strobe    = strobe_q;
  assign rw        = rw_q;
  assign addr      = addr_q;
  assign d_out     = dout_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_last  = rsp_last_q;

endmodule

// File: doc/mmr_initiator.md
Name: mmr_initiator

Overview:
- Bus initiator for the strobe/rw/addr/data register bus that memory-mapped registers respond on.
- Accepts a command (single access or incrementing burst) over a valid/ready handshake and drives the bus strobe cycles.
- For reads, captures the registered read data one cycle after each strobe; returns responses over a second valid/ready handshake.
- Sits between a CPU/debug agent and the register bus; at most one command outstanding.

Parameters:
- ABITS, 32, address width.
- PBITS, 32, data width.
- LBITS, 4, burst length field width; a burst is req_len+1 words.
- ASTEP, 1, address increment per burst word (mod 2^ABITS).

Ports:
- clk  in  1  clock, all logic on posedge.
- reset_n  in  1  synchronous active-low reset.
- req_valid  in  1  command valid.
- req_ready  out  1  command accepted when req_valid && req_ready.
- req_rw  in  1  1=write, 0=read.
- req_addr  in  ABITS  start address.
- req_data  in  PBITS  write data, same value written to every word of the burst.
- req_len  in  LBITS  words minus one.
- strobe  out  1  bus strobe.
- rw  out  1  bus direction, 1=write.
- addr  out  ABITS  bus address.
- d_out  out  PBITS  bus write data, to the responders' d_in.
- d_in  in  PBITS  bus read data, from the responders' d_out.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_data  out  PBITS  read word; 0 for write acks.
- rsp_last  out  1  final response of the command.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (reset_n=0 at posedge): state=IDLE, strobe=0, rw=0, addr=0, d_out=0, rsp_valid=0, rsp_data=0, rsp_last=0, word counter=0.
- Reset mid-command aborts it: no further strobes or responses.
- All outputs are registered; req_ready = (state==IDLE) && reset_n.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - On accept, latch rw, addr, d_out and remaining=req_len; go to ISSUE.
  - strobe is first high the cycle after acceptance.
- ISSUE (strobe=1 for this cycle, addr/rw/d_out stable):
  - Write with remaining>0: stay in ISSUE; next cycle addr+=ASTEP and remaining-=1. Write bursts therefore strobe on len+1 consecutive cycles.
  - Write with remaining==0: go to RESP with rsp_data=0, rsp_last=1.
  - Read: go to CAPTURE; strobe drops to 0.
- CAPTURE (strobe=0):
  - At the end of this cycle, register d_in into rsp_data.
  - Set rsp_last = (remaining==0); go to RESP.
  - Read latency: strobe in cycle N, d_in sampled in cycle N+1, rsp_valid high in cycle N+2.
- RESP:
  - rsp_valid=1; hold rsp_data and rsp_last stable until rsp_ready.
  - On handshake, if rsp_last: go to IDLE, rsp_valid=0.
  - Otherwise (read burst): addr+=ASTEP, remaining-=1, go to ISSUE.
  - rsp_ready is ignored while rsp_valid=0.
- Throughput:
  - Write burst of L words: strobes in L consecutive cycles, then one ack.
  - Read: at best one word per 3 cycles (ISSUE, CAPTURE, RESP with rsp_ready=1).
- Address wraps modulo 2^ABITS; e.g. ABITS=32, addr 0xFFFFFFFF + 1 = 0x00000000.
- req_* inputs are ignored outside IDLE. rw, addr and d_out are held between strobes; responders only qualify on strobe.
- busy=1 from the cycle after acceptance until the cycle after the last response handshake.

Test Plan:
- Reset values: hold reset_n=0 for 3 cycles with req_valid=1 -> all outputs 0, req_ready=0, no strobe; release -> req_ready=1.
- Single write: req_rw=1, addr=0x10, data=0xDEADBEEF, len=0 -> one strobe cycle with rw=1, addr=0x10, d_out=0xDEADBEEF; next cycle rsp_valid=1, rsp_data=0, rsp_last=1.
- Read burst with register model at 0x20..0x22 returning 0xA,0xB,0xC: len=2, rsp_ready=1 -> strobes at addr 0x20/0x21/0x22 spaced 3 cycles apart; responses 0xA,0xB,0xC; rsp_last only on 0xC.
- Backpressure: same read burst with rsp_ready=0 for 5 cycles on the first response -> rsp_valid and rsp_data=0xA held; no strobe until the handshake.
- Wrap: write burst addr=0xFFFFFFFF, len=1 -> strobes at 0xFFFFFFFF then 0x00000000 on consecutive cycles.
- Abort: assert reset_n=0 during a 4-word read after the 2nd response -> no further strobe or rsp_valid; a new command after release executes normally.
